// File: rtl/l_input_port_ctrl.sv
// Local (PE) input port controller for a mesh NoC router: buffers PE flits,
// XY-routes the head flit, requests the chosen output arbiter, streams the
// packet to the crossbar and pulses a one-hot release when the tail leaves.
module l_input_port_ctrl #(
   parameter int unsigned ADDR_W    = 3,
   parameter int unsigned PAYLOAD_W = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ROUTER_X  = 0,
   parameter int unsigned ROUTER_Y  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PAYLOAD_W+1:0] l_flit_i,
   input  logic                 l_valid_i,
   output logic                 l_ready_o,
   output logic [2:0]           l_nexthop_addr_o,
   input  logic [4:0]           grant_i,
   output logic [PAYLOAD_W+1:0] xbar_flit_o,
   output logic                 xbar_valid_o,
   input  logic                 xbar_ready_i,
   output logic [4:0]           release_o,
   output logic                 err_o
);

   localparam int unsigned FLIT_W = PAYLOAD_W + 2;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   localparam logic [ADDR_W-1:0] RX = ADDR_W'(ROUTER_X);
   localparam logic [ADDR_W-1:0] RY = ADDR_W'(ROUTER_Y);

   localparam logic [2:0] DIR_N    = 3'b000;
   localparam logic [2:0] DIR_S    = 3'b001;
   localparam logic [2:0] DIR_W    = 3'b010;
   localparam logic [2:0] DIR_E    = 3'b011;
   localparam logic [2:0] DIR_L    = 3'b100;
   localparam logic [2:0] DIR_NONE = 3'b111;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] XFER = 2'd2;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              ready_q, empty_c, push_c, pop_c;
   logic [FLIT_W-1:0] head_c;
   logic [2:0]        route_c;

   logic [1:0] state, state_nxt;
   logic [2:0] dir_q, dir_nxt, nexthop_q, nexthop_nxt;
   logic [4:0] release_q, release_nxt;
   logic       err_q, err_nxt, xbar_valid_q, xbar_valid_nxt;

   // XY dimension-order route: resolve x first, then y, else eject locally
   function automatic logic [2:0] xy_route(input logic [ADDR_W-1:0] dx,
                                           input logic [ADDR_W-1:0] dy);
      if (dx > RX)      return DIR_E;
      else if (dx < RX) return DIR_W;
      else if (dy > RY) return DIR_N;
      else if (dy < RY) return DIR_S;
      else              return DIR_L;
   endfunction

   // One-hot {n,s,w,e,l} mask for a direction code; N maps to bit 4
   function automatic logic [4:0] dir_mask(input logic [2:0] d);
      return 5'b10000 >> d;
   endfunction

   assign empty_c = (count == '0);
   assign head_c  = mem[rd_ptr];
   assign push_c  = l_valid_i & ready_q;
   assign route_c = xy_route(head_c[2*ADDR_W-1:ADDR_W], head_c[ADDR_W-1:0]);

   // Next-state, pop decision and registered-output next values
   always_comb begin
      state_nxt   = state;
      dir_nxt     = dir_q;
      nexthop_nxt = nexthop_q;
      release_nxt = '0;
      err_nxt     = 1'b0;
      pop_c       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty_c) begin
               if (head_c[FLIT_W-1]) begin
                  dir_nxt     = route_c;
                  nexthop_nxt = route_c;
                  state_nxt   = REQ;
               end else begin
                  // stray non-head flit at packet start is discarded
                  pop_c   = 1'b1;
                  err_nxt = 1'b1;
               end
            end
         end
         REQ: begin
            if (|(grant_i & dir_mask(dir_q))) state_nxt = XFER;
         end
         XFER: begin
            if (xbar_valid_q && xbar_ready_i) begin
               pop_c = 1'b1;
               if (head_c[FLIT_W-2]) begin
                  release_nxt = dir_mask(dir_q);
                  nexthop_nxt = DIR_NONE;
                  state_nxt   = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO occupancy update
   always_comb begin
      count_nxt = count;
      case ({push_c, pop_c})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   assign xbar_valid_nxt = (state_nxt == XFER) && (count_nxt != '0);

   // State, pointers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         dir_q        <= DIR_NONE;
         nexthop_q    <= DIR_NONE;
         release_q    <= '0;
         err_q        <= 1'b0;
         xbar_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
      end else begin
         state        <= state_nxt;
         dir_q        <= dir_nxt;
         nexthop_q    <= nexthop_nxt;
         release_q    <= release_nxt;
         err_q        <= err_nxt;
         xbar_valid_q <= xbar_valid_nxt;
         ready_q      <= (count_nxt < CNT_W'(DEPTH));
         count        <= count_nxt;
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // FIFO storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= l_flit_i;
   end

   assign l_ready_o        = ready_q;
   assign l_nexthop_addr_o = nexthop_q;
   assign xbar_flit_o      = head_c;
   assign xbar_valid_o     = xbar_valid_q;
   assign release_o        = release_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_l_input_port_ctrl.sv
// Directed bench for l_input_port_ctrl at router position (1,1).
module tb_l_input_port_ctrl;

   localparam int unsigned FLIT_W = 34;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [FLIT_W-1:0] l_flit_i = '0;
   logic              l_valid_i = 1'b0;
   logic              l_ready_o;
   logic [2:0]        l_nexthop_addr_o;
   logic [4:0]        grant_i = '0;
   logic [FLIT_W-1:0] xbar_flit_o;
   logic              xbar_valid_o;
   logic              xbar_ready_i = 1'b0;
   logic [4:0]        release_o;
   logic              err_o;

   int errors = 0;
   int checks = 0;

   logic [FLIT_W-1:0] got [32];
   int                n_got;
   int                rel_cnt;
   logic [4:0]        rel_val;
   logic [2:0]        nh_at_rel;
   int                err_cnt;

   l_input_port_ctrl #(
      .ADDR_W(3), .PAYLOAD_W(32), .DEPTH(4), .ROUTER_X(1), .ROUTER_Y(1)
   ) dut (
      .clk(clk), .reset(reset),
      .l_flit_i(l_flit_i), .l_valid_i(l_valid_i), .l_ready_o(l_ready_o),
      .l_nexthop_addr_o(l_nexthop_addr_o), .grant_i(grant_i),
      .xbar_flit_o(xbar_flit_o), .xbar_valid_o(xbar_valid_o),
      .xbar_ready_i(xbar_ready_i), .release_o(release_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [FLIT_W-1:0] mk(input logic h, input logic t,
                                            input logic [25:0] tag,
                                            input logic [2:0] dx,
                                            input logic [2:0] dy);
      return {h, t, tag, dx, dy};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      l_valid_i    = 1'b0;
      grant_i      = '0;
      xbar_ready_i = 1'b0;
      reset        = 1'b1;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic push_flit(input logic [FLIT_W-1:0] f);
      l_valid_i = 1'b1;
      l_flit_i  = f;
      tick;
      l_valid_i = 1'b0;
   endtask

   // Runs a fixed number of cycles, recording crossbar pops and pulses
   task automatic run_collect(input int cycles);
      n_got = 0; rel_cnt = 0; rel_val = '0; nh_at_rel = '0; err_cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         if (xbar_valid_o && xbar_ready_i && n_got < 32) begin
            got[n_got] = xbar_flit_o;
            n_got++;
         end
         if (release_o != '0) begin
            rel_cnt++; rel_val = release_o; nh_at_rel = l_nexthop_addr_o;
         end
         if (err_o) err_cnt++;
         tick;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      checks++; if (l_nexthop_addr_o !== 3'b111) begin errors++; $display("FAIL reset_nexthop: got %b expected 111", l_nexthop_addr_o); end
      checks++; if (xbar_valid_o !== 1'b0) begin errors++; $display("FAIL reset_xbar_valid: got %b expected 0", xbar_valid_o); end
      checks++; if (release_o !== 5'b0) begin errors++; $display("FAIL reset_release: got %b expected 00000", release_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
      reset = 1'b0;
      tick;
      checks++; if (l_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", l_ready_o); end
   endtask

   task automatic test_basic_packet;
      logic [FLIT_W-1:0] f [3];
      f[0] = mk(1'b1, 1'b0, 26'h00A1, 3'd3, 3'd1);
      f[1] = mk(1'b0, 1'b0, 26'h00A2, 3'd5, 3'd6);
      f[2] = mk(1'b0, 1'b1, 26'h00A3, 3'd2, 3'd7);
      do_reset;
      push_flit(f[0]);
      checks++; if (l_nexthop_addr_o !== 3'b111) begin errors++; $display("FAIL basic_nexthop_latency: got %b expected 111", l_nexthop_addr_o); end
      push_flit(f[1]);
      checks++; if (l_nexthop_addr_o !== 3'b011) begin errors++; $display("FAIL basic_nexthop_e: got %b expected 011", l_nexthop_addr_o); end
      push_flit(f[2]);
      tick;
      tick;
      checks++; if (xbar_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_in_req: got %b expected 0", xbar_valid_o); end
      grant_i = 5'b00010;
      xbar_ready_i = 1'b1;
      run_collect(10);
      checks++; if (n_got !== 3) begin errors++; $display("FAIL basic_flit_count: got %0d expected 3", n_got); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (got[i] !== f[i]) begin errors++; $display("FAIL basic_flit%0d: got %h expected %h", i, got[i], f[i]); end
      end
      checks++; if (rel_cnt !== 1 || rel_val !== 5'b00010) begin errors++; $display("FAIL basic_release: got %b x%0d expected 00010 x1", rel_val, rel_cnt); end
      checks++; if (nh_at_rel !== 3'b111) begin errors++; $display("FAIL basic_nexthop_at_release: got %b expected 111", nh_at_rel); end
      checks++; if (l_nexthop_addr_o !== 3'b111) begin errors++; $display("FAIL basic_nexthop_idle: got %b expected 111", l_nexthop_addr_o); end
   endtask

   task automatic test_routing;
      logic [2:0] dx [4];
      logic [2:0] dy [4];
      logic [2:0] ex [4];
      dx[0] = 3'd0; dy[0] = 3'd1; ex[0] = 3'b010;
      dx[1] = 3'd1; dy[1] = 3'd2; ex[1] = 3'b000;
      dx[2] = 3'd1; dy[2] = 3'd0; ex[2] = 3'b001;
      dx[3] = 3'd1; dy[3] = 3'd1; ex[3] = 3'b100;
      for (int i = 0; i < 4; i++) begin
         do_reset;
         push_flit(mk(1'b1, 1'b1, 26'(i), dx[i], dy[i]));
         tick;
         checks++; if (l_nexthop_addr_o !== ex[i]) begin errors++; $display("FAIL route_%0d: got %b expected %b", i, l_nexthop_addr_o, ex[i]); end
      end
   endtask

   task automatic test_single_flit;
      logic [FLIT_W-1:0] f;
      f = mk(1'b1, 1'b1, 26'h0B0B, 3'd1, 3'd2);
      do_reset;
      push_flit(f);
      tick;
      checks++; if (l_nexthop_addr_o !== 3'b000) begin errors++; $display("FAIL single_nexthop_n: got %b expected 000", l_nexthop_addr_o); end
      grant_i = 5'b10000;
      xbar_ready_i = 1'b1;
      run_collect(8);
      checks++; if (n_got !== 1 || got[0] !== f) begin errors++; $display("FAIL single_flit: got %0d flits first %h expected 1 flit %h", n_got, got[0], f); end
      checks++; if (rel_cnt !== 1 || rel_val !== 5'b10000) begin errors++; $display("FAIL single_release: got %b x%0d expected 10000 x1", rel_val, rel_cnt); end
   endtask

   task automatic test_wrong_grant;
      logic [FLIT_W-1:0] f;
      f = mk(1'b1, 1'b1, 26'h0C0C, 3'd3, 3'd1);
      do_reset;
      push_flit(f);
      tick;
      grant_i = 5'b10000;
      xbar_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++; if (xbar_valid_o !== 1'b0 || l_nexthop_addr_o !== 3'b011) begin errors++; $display("FAIL wrong_grant_hold%0d: got valid=%b nexthop=%b expected valid=0 nexthop=011", i, xbar_valid_o, l_nexthop_addr_o); end
      end
      grant_i = 5'b00010;
      run_collect(6);
      checks++; if (n_got !== 1 || got[0] !== f) begin errors++; $display("FAIL wrong_grant_xfer: got %0d flits first %h expected 1 flit %h", n_got, got[0], f); end
      checks++; if (rel_cnt !== 1 || rel_val !== 5'b00010) begin errors++; $display("FAIL wrong_grant_release: got %b x%0d expected 00010 x1", rel_val, rel_cnt); end
   endtask

   task automatic test_fifo_full_wrap;
      logic [FLIT_W-1:0] pk [10];
      logic              exp_rdy [4];
      int                idx;
      logic              will_push;
      for (int i = 0; i < 10; i++)
         pk[i] = mk(i == 0, i == 9, 26'h100 + 26'(i), 3'(i == 0 ? 3 : i), 3'(i == 0 ? 1 : 7 - i % 8));
      exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1; exp_rdy[3] = 1'b0;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         push_flit(pk[i]);
         checks++; if (l_ready_o !== exp_rdy[i]) begin errors++; $display("FAIL full_ready_after_push%0d: got %b expected %b", i, l_ready_o, exp_rdy[i]); end
      end
      idx = 4;
      grant_i = 5'b00010;
      n_got = 0; rel_cnt = 0; rel_val = '0;
      for (int c = 0; c < 60; c++) begin
         l_valid_i    = (idx < 10);
         l_flit_i     = (idx < 10) ? pk[idx] : '0;
         xbar_ready_i = (c % 2 == 0);
         will_push    = l_valid_i && l_ready_o;
         if (xbar_valid_o && xbar_ready_i && n_got < 32) begin
            got[n_got] = xbar_flit_o;
            n_got++;
         end
         if (release_o != '0) begin rel_cnt++; rel_val = release_o; end
         tick;
         if (will_push) idx++;
      end
      l_valid_i = 1'b0;
      checks++; if (idx !== 10) begin errors++; $display("FAIL wrap_all_pushed: got %0d expected 10", idx); end
      checks++; if (n_got !== 10) begin errors++; $display("FAIL wrap_flit_count: got %0d expected 10", n_got); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (got[i] !== pk[i]) begin errors++; $display("FAIL wrap_flit%0d: got %h expected %h", i, got[i], pk[i]); end
      end
      checks++; if (rel_cnt !== 1 || rel_val !== 5'b00010) begin errors++; $display("FAIL wrap_release: got %b x%0d expected 00010 x1", rel_val, rel_cnt); end
   endtask

   task automatic test_err_and_reset;
      do_reset;
      push_flit(mk(1'b0, 1'b0, 26'h0DEAD, 3'd3, 3'd3));
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_before_drop: got %b expected 0", err_o); end
      tick;
      checks++; if (err_o !== 1'b1 || l_nexthop_addr_o !== 3'b111) begin errors++; $display("FAIL err_pulse: got err=%b nexthop=%b expected err=1 nexthop=111", err_o, l_nexthop_addr_o); end
      push_flit(mk(1'b1, 1'b1, 26'h0E0E, 3'd0, 3'd1));
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", err_o); end
      tick;
      checks++; if (l_nexthop_addr_o !== 3'b010) begin errors++; $display("FAIL err_dropped_next_head: got %b expected 010", l_nexthop_addr_o); end

      do_reset;
      push_flit(mk(1'b1, 1'b0, 26'h0F01, 3'd3, 3'd1));
      push_flit(mk(1'b0, 1'b0, 26'h0F02, 3'd0, 3'd0));
      push_flit(mk(1'b0, 1'b0, 26'h0F03, 3'd0, 3'd0));
      grant_i = 5'b00010;
      tick;
      checks++; if (xbar_valid_o !== 1'b1) begin errors++; $display("FAIL midreset_in_xfer: got %b expected 1", xbar_valid_o); end
      xbar_ready_i = 1'b1;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++; if (l_nexthop_addr_o !== 3'b111 || xbar_valid_o !== 1'b0 || l_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_state: got nexthop=%b valid=%b ready=%b expected 111 0 1", l_nexthop_addr_o, xbar_valid_o, l_ready_o); end
      run_collect(8);
      checks++; if (rel_cnt !== 0) begin errors++; $display("FAIL midreset_release: got %0d pulses expected 0", rel_cnt); end
      checks++; if (n_got !== 0 || l_nexthop_addr_o !== 3'b111) begin errors++; $display("FAIL midreset_flushed: got %0d flits nexthop=%b expected 0 flits 111", n_got, l_nexthop_addr_o); end
   endtask

   initial begin
      test_reset;
      test_basic_packet;
      test_routing;
      test_single_flit;
      test_wrong_grant;
      test_fifo_full_wrap;
      test_err_and_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
